// File: rtl/evm_ballot_unit.sv
// Ballot-controlled vote tally for N_CAND candidates with a sequential winner/tie scan at close.
// Optional macro EVM_SATURATE_EN: counts saturate and raise sticky ovf instead of wrapping.
module evm_ballot_unit #(
  parameter  int N_CAND = 3,
  parameter  int CNT_W  = 32,
  localparam int IDX_W  = $clog2(N_CAND),
  localparam int TOT_W  = CNT_W + IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    voter_en,
  input  logic [N_CAND-1:0]       cand,
  input  logic                    voting_over,
  output logic                    ready,
  output logic                    vote_ack,
  output logic                    vote_err,
  output logic [N_CAND*CNT_W-1:0] counts,
  output logic [TOT_W-1:0]        total,
  output logic [IDX_W-1:0]        winner,
  output logic                    tie,
  output logic                    result_valid,
  output logic                    ovf,
  output logic [2:0]              dbg_state_o
);

  // Handshake: a ballot is consumed by exactly one single-button rising edge while
  // ready=1; vote_ack (accepted) or vote_err (multi-press) pulses the cycle after.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_RELEASE = 3'd2,
    S_TALLY   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [N_CAND-1:0] ONE_HOT_LSB = N_CAND'(1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_CAND - 1);

  state_t             state_q, state_d;
  logic [N_CAND-1:0]  cand_q;
  logic [CNT_W-1:0]   cnt_q [N_CAND];
  logic [CNT_W-1:0]   cnt_d [N_CAND];
  logic [TOT_W-1:0]   total_q, total_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic               tie_q, tie_d;
`ifdef EVM_SATURATE_EN
  logic               ovf_q, ovf_d;
`endif

  logic [N_CAND-1:0]  rise;
  logic               single_press;
  logic               multi_press;
  logic [IDX_W-1:0]   press_idx;
  logic               record;
  logic [CNT_W-1:0]   scan_cnt;

  assign rise         = cand & ~cand_q;
  assign single_press = (rise != '0) && ((rise & (rise - ONE_HOT_LSB)) == '0);
  assign multi_press  = (rise != '0) && !single_press;
  assign scan_cnt     = cnt_q[scan_q];

  always_comb begin
    press_idx = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (rise[i]) press_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    total_d  = total_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    scan_d   = scan_q;
    max_d    = max_q;
    winner_d = winner_q;
    tie_d    = tie_q;
`ifdef EVM_SATURATE_EN
    ovf_d    = ovf_q;
`endif
    record   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (voting_over)   state_d = S_TALLY;
        else if (voter_en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (single_press) begin
          record  = 1'b1;
          state_d = S_RELEASE;
        end else if (multi_press) begin
          err_d = 1'b1;
        end
        if (voting_over) state_d = S_TALLY;
      end
      S_RELEASE: begin
        if (voting_over)       state_d = S_TALLY;
        else if (cand == '0)   state_d = S_IDLE;
      end
      S_TALLY: begin
        // Strictly-greater update keeps ties on the lowest index.
        if (scan_q == '0) begin
          max_d    = scan_cnt;
          winner_d = '0;
          tie_d    = 1'b0;
        end else if (scan_cnt > max_q) begin
          max_d    = scan_cnt;
          winner_d = scan_q;
          tie_d    = 1'b0;
        end else if (scan_cnt == max_q) begin
          tie_d = 1'b1;
        end
        if (scan_q == LAST_IDX) state_d = S_DONE;
        else                    scan_d  = scan_q + IDX_W'(1);
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_TALLY && state_q != S_TALLY) begin
      scan_d   = '0;
      max_d    = '0;
      winner_d = '0;
      tie_d    = 1'b0;
    end

    if (record) begin
      ack_d   = 1'b1;
      total_d = total_q + TOT_W'(1);
`ifdef EVM_SATURATE_EN
      if (&cnt_q[press_idx]) ovf_d = 1'b1;
      else                   cnt_d[press_idx] = cnt_q[press_idx] + CNT_W'(1);
`else
      cnt_d[press_idx] = cnt_q[press_idx] + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      for (int i = 0; i < N_CAND; i++) cnt_q[i] <= '0;
      total_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      scan_q   <= '0;
      max_q    <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
`ifdef EVM_SATURATE_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand;
      for (int i = 0; i < N_CAND; i++) cnt_q[i] <= cnt_d[i];
      total_q  <= total_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      scan_q   <= scan_d;
      max_q    <= max_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
`ifdef EVM_SATURATE_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  for (genvar g = 0; g < N_CAND; g++) begin : g_counts
    assign counts[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign ready        = (state_q == S_ARMED);
  assign result_valid = (state_q == S_DONE);
  assign vote_ack     = ack_q;
  assign vote_err     = err_q;
  assign total        = total_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign dbg_state_o  = state_q;
`ifdef EVM_SATURATE_EN
  assign ovf          = ovf_q;
`else
  assign ovf          = 1'b0;
`endif

endmodule
